// File: rtl/barrel_pkg.sv
// Shared constants and types for the barrel-threaded fetch stage.
// Every thread starts at RESET_PC; bubbles carry the canonical NOP.
package barrel_pkg;

  localparam int          ADDRESS_WIDTH = 32;
  localparam int          DATA_WIDTH    = 32;
  localparam int          BITS_THREADS  = 3;
  localparam int          NUM_THREADS   = 2 ** BITS_THREADS;
  localparam logic [31:0] RESET_PC      = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

  typedef logic [BITS_THREADS-1:0] tid_t;

endpackage

// File: rtl/rr_next_thread.sv
// Round-robin successor: next enabled thread strictly after cur.
// The mask is rotated, priority-encoded, then the offset is added back.
module rr_next_thread #(
  parameter  int BITS = barrel_pkg::BITS_THREADS,
  localparam int N    = 2 ** BITS
) (
  input  logic [BITS-1:0] cur,
  input  logic [N-1:0]    en,
  output logic [BITS-1:0] next,
  output logic            any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [BITS-1:0] off;

  assign dbl = {en, en};
  assign any = |en;

  // rot[i] = en[(cur + 1 + i) mod N]
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = dbl[int'(cur) + 1 + i];
    end
  end

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = BITS'(i);
    end
  end

  // Wraps naturally because N is a power of two.
  assign next = cur + BITS'(1) + off;

endmodule

// File: rtl/barrel_fetch.sv
// Barrel fetch stage: one PC per hardware thread, round-robin thread
// pick, combinational imem read, execute redirects into thread PCs.
module barrel_fetch #(
  parameter int                     ADDRESS_WIDTH = barrel_pkg::ADDRESS_WIDTH,
  parameter int                     DATA_WIDTH    = barrel_pkg::DATA_WIDTH,
  parameter int                     BITS_THREADS  = barrel_pkg::BITS_THREADS,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = ADDRESS_WIDTH'(barrel_pkg::RESET_PC)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall_i,
  input  logic [2**BITS_THREADS-1:0] thread_en_i,
  input  logic                       redirect_i,
  input  logic [BITS_THREADS-1:0]    redirect_tid_i,
  input  logic [ADDRESS_WIDTH-1:0]   redirect_pc_i,
  output logic [ADDRESS_WIDTH-1:0]   imem_addr_o,
  input  logic [DATA_WIDTH-1:0]      imem_rdata_i,
  output logic [ADDRESS_WIDTH-1:0]   pc_f_o,
  output logic [ADDRESS_WIDTH-1:0]   pc_plus4_f_o,
  output logic [DATA_WIDTH-1:0]      instr_f_o,
  output logic [BITS_THREADS-1:0]    tid_f_o,
  output logic                       valid_f_o
);

  import barrel_pkg::*;

  localparam int NT = 2 ** BITS_THREADS;

  logic [ADDRESS_WIDTH-1:0] pc_q [NT];
  logic [BITS_THREADS-1:0]  tid_q;
  logic [BITS_THREADS-1:0]  tid_next;
  logic                     any_en;
  logic [ADDRESS_WIDTH-1:0] cur_pc;
  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic                     valid;

  rr_next_thread #(
    .BITS (BITS_THREADS)
  ) u_rr (
    .cur  (tid_q),
    .en   (thread_en_i),
    .next (tid_next),
    .any  (any_en)
  );

  assign cur_pc   = pc_q[tid_q];
  assign pc_plus4 = cur_pc + ADDRESS_WIDTH'(4);
  assign valid    = thread_en_i[tid_q];

  assign imem_addr_o  = cur_pc;
  assign pc_f_o       = cur_pc;
  assign pc_plus4_f_o = pc_plus4;
  assign tid_f_o      = tid_q;
  assign valid_f_o    = valid;
  assign instr_f_o    = valid ? imem_rdata_i
                              : DATA_WIDTH'(NOP_INSTR);

  // Redirect is written last so it beats the +4 of the same thread.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NT; t++) begin
        pc_q[t] <= RESET_PC;
      end
      tid_q <= '0;
    end else begin
      if (!stall_i) begin
        if (valid) pc_q[tid_q] <= pc_plus4;
        if (any_en) tid_q <= tid_next;
      end
      if (redirect_i) pc_q[redirect_tid_i] <= redirect_pc_i;
    end
  end

endmodule

// File: tb/tb_barrel_fetch.sv
// Directed bench for barrel_fetch: round-robin order, masks, bubbles,
// redirects, stalls, mid-run reset and PC wrap.
module tb_barrel_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [7:0]  thread_en;
  logic        redirect;
  logic [2:0]  redirect_tid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic [31:0] instr_f;
  logic [2:0]  tid_f;
  logic        valid_f;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr;

  barrel_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall),
    .thread_en_i    (thread_en),
    .redirect_i     (redirect),
    .redirect_tid_i (redirect_tid),
    .redirect_pc_i  (redirect_pc),
    .imem_addr_o    (imem_addr),
    .imem_rdata_i   (imem_rdata),
    .pc_f_o         (pc_f),
    .pc_plus4_f_o   (pc_plus4_f),
    .instr_f_o      (instr_f),
    .tid_f_o        (tid_f),
    .valid_f_o      (valid_f)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Valid fetch of thread tid at pc; imem echoes the address.
  task automatic see(input string tag, input int tid,
                     input logic [31:0] pc);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    @(negedge clk);
    check({tag, ".tid"},   32'(tid_f),   32'(tid));
    check({tag, ".pc"},    pc_f,         pc);
    check({tag, ".pc4"},   pc_plus4_f,   p4);
    check({tag, ".valid"}, 32'(valid_f), 32'd1);
    check({tag, ".instr"}, instr_f,      pc);
  endtask

  task automatic bubble(input string tag, input int tid,
                        input logic [31:0] pc);
    @(negedge clk);
    check({tag, ".tid"},   32'(tid_f),   32'(tid));
    check({tag, ".pc"},    pc_f,         pc);
    check({tag, ".valid"}, 32'(valid_f), 32'd0);
    check({tag, ".instr"}, instr_f,      32'h0000_0013);
  endtask

  task automatic tid_only(input string tag, input int tid);
    @(negedge clk);
    check({tag, ".tid"}, 32'(tid_f), 32'(tid));
  endtask

  initial begin
    rst          = 1'b1;
    stall        = 1'b0;
    thread_en    = 8'hFF;
    redirect     = 1'b0;
    redirect_tid = '0;
    redirect_pc  = '0;
    tick();
    tick();
    rst = 1'b0;

    // Full round-robin; first entry is the reset state.
    for (int k = 0; k < 16; k++) begin
      see("rr", k % 8, 32'((k / 8) * 4));
      tick();
    end

    // Sparse mask {2,5}; thread 0 now presented but disabled.
    thread_en = 8'b0010_0100;
    bubble("mask0", 0, 32'h8);
    tick();
    see("m25a", 2, 32'h8);  tick();
    see("m25b", 5, 32'h8);  tick();
    see("m25c", 2, 32'hC);  tick();
    see("m25d", 5, 32'hC);  tick();

    // Single enabled thread reselected every cycle.
    thread_en = 8'b0000_0100;
    see("solo0", 2, 32'h10); tick();
    see("solo1", 2, 32'h14); tick();
    see("solo2", 2, 32'h18); tick();

    // Nothing enabled: everything frozen.
    thread_en = 8'h00;
    for (int k = 0; k < 10; k++) begin
      bubble("none", 2, 32'h1C);
      tick();
    end

    // Redirect thread 4 while it presents 0x8.
    thread_en = 8'hFF;
    see("re2", 2, 32'h1C); tick();
    see("re3", 3, 32'h8);  tick();
    redirect     = 1'b1;
    redirect_tid = 3'd4;
    redirect_pc  = 32'h100;
    see("re4", 4, 32'h8);  tick();
    redirect = 1'b0;
    see("re5", 5, 32'h10); tick();
    see("re6", 6, 32'h8);  tick();
    see("re7", 7, 32'h8);  tick();
    see("re0", 0, 32'h8);  tick();
    see("re1", 1, 32'h8);  tick();
    see("re2b", 2, 32'h20); tick();
    see("re3b", 3, 32'hC);  tick();
    see("re4b", 4, 32'h100); tick();

    // Redirect 6 to 0x20 one cycle ahead, then stall on it.
    redirect     = 1'b1;
    redirect_tid = 3'd6;
    redirect_pc  = 32'h20;
    see("pre5", 5, 32'h14); tick();
    redirect = 1'b0;
    stall    = 1'b1;
    see("st1", 6, 32'h20); tick();
    redirect     = 1'b1;
    redirect_tid = 3'd6;
    redirect_pc  = 32'h80;
    see("st2", 6, 32'h20); tick();
    redirect = 1'b0;
    see("st3", 6, 32'h80); tick();
    stall = 1'b0;
    see("rel", 6, 32'h80); tick();
    for (int k = 0; k < 7; k++) begin
      tid_only("walk", (7 + k) % 8);
      tick();
    end

    // Thread 7 to the top of memory for the wrap check.
    redirect     = 1'b1;
    redirect_tid = 3'd7;
    redirect_pc  = 32'hFFFF_FFFC;
    see("adv6", 6, 32'h84); tick();

    // Reset alongside stall and redirect.
    rst          = 1'b1;
    stall        = 1'b1;
    redirect     = 1'b1;
    redirect_tid = 3'd3;
    redirect_pc  = 32'h500;
    see("wrap", 7, 32'hFFFF_FFFC);
    check("wrap.pc4z", pc_plus4_f, 32'h0);
    tick();
    rst      = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    for (int k = 0; k < 8; k++) begin
      see("rst2", k, 32'h0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
